regbank_port_arbiter: RTL

//  Shares the register bank's single read port (RS/RX/RK) and single write port (RD/WB) among NREQ requesters
//  (e.g. decode, writeback, debug loader). Round-robin arbitration, one transaction in flight at a time.

---
 rtl/regbank_port_arbiter.sv | 209 ++++++++++++++++++++
 1 files changed

// File: rtl/regbank_port_arbiter.sv
// Round-robin arbiter sharing the register bank's read and write ports among NREQ requesters.
// One transaction in flight at a time; writes aimed at the PC slot are refused with rsp_err.
//
// state  | meaning
// IDLE   | no transaction in flight; pending requests are arbitrated
// ACCESS | bank RE or WE strobe asserted for exactly this cycle
// RDWAIT | bank read data valid; captured into rsp_* at the next edge
// RESP   | rsp_valid pulse to the owning requester
module regbank_port_arbiter #(
    parameter int BUS    = 32,
    parameter int DIR    = 4,
    parameter int NREQ   = 3,
    parameter int PC_IDX = 2**DIR - 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NREQ-1:0]     req,
    input  logic [NREQ-1:0]     req_we,
    input  logic [NREQ*DIR-1:0] req_rd,
    input  logic [NREQ*DIR-1:0] req_rs,
    input  logic [NREQ*DIR-1:0] req_rx,
    input  logic [NREQ*DIR-1:0] req_rk,
    input  logic [NREQ*BUS-1:0] req_wb,
    output logic [NREQ-1:0]     gnt,
    output logic [NREQ-1:0]     rsp_valid,
    output logic                rsp_err,
    output logic [BUS-1:0]      rsp_rsd,
    output logic [BUS-1:0]      rsp_rxd,
    output logic [BUS-1:0]      rsp_rkd,
    output logic                busy,
    output logic                bank_re,
    output logic                bank_we,
    output logic [DIR-1:0]      bank_rd,
    output logic [DIR-1:0]      bank_rs,
    output logic [DIR-1:0]      bank_rx,
    output logic [DIR-1:0]      bank_rk,
    output logic [BUS-1:0]      bank_wb,
    input  logic [BUS-1:0]      bank_rsd,
    input  logic [BUS-1:0]      bank_rxd,
    input  logic [BUS-1:0]      bank_rkd
);

    localparam int PW = $clog2(NREQ);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RDWAIT = 2'd2,
        RESP   = 2'd3
    } state_t;

    state_t          state, state_nx;
    logic [PW-1:0]   ptr, ptr_nx;
    logic [PW-1:0]   owner, owner_nx;
    logic            is_wr, is_wr_nx;
    logic            err, err_nx;

    logic [NREQ-1:0] gnt_nx, rsp_valid_nx;
    logic            rsp_err_nx, busy_nx, re_nx, we_nx;
    logic [BUS-1:0]  rsd_nx, rxd_nx, rkd_nx, wb_nx;
    logic [DIR-1:0]  rd_nx, rs_nx, rx_nx, rk_nx;

    logic [DIR-1:0]  rd_a [NREQ];
    logic [DIR-1:0]  rs_a [NREQ];
    logic [DIR-1:0]  rx_a [NREQ];
    logic [DIR-1:0]  rk_a [NREQ];
    logic [BUS-1:0]  wb_a [NREQ];

    logic            found;
    logic [PW-1:0]   win;
    logic [PW-1:0]   cand;
    logic            pc_hit;

    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            rd_a[i] = req_rd[i*DIR +: DIR];
            rs_a[i] = req_rs[i*DIR +: DIR];
            rx_a[i] = req_rx[i*DIR +: DIR];
            rk_a[i] = req_rk[i*DIR +: DIR];
            wb_a[i] = req_wb[i*BUS +: BUS];
        end
    end

    // Scan starts just after the last winner so every requester waits at most NREQ-1 grants.
    always_comb begin
        found = 1'b0;
        win   = '0;
        cand  = '0;
        for (int k = 1; k <= NREQ; k++) begin
            cand = PW'((int'(ptr) + k) % NREQ);
            if (!found && req[cand]) begin
                found = 1'b1;
                win   = cand;
            end
        end
    end

    assign pc_hit = (rd_a[win] == DIR'(PC_IDX));

    always_comb begin
        state_nx     = state;
        ptr_nx       = ptr;
        owner_nx     = owner;
        is_wr_nx     = is_wr;
        err_nx       = err;
        gnt_nx       = '0;
        rsp_valid_nx = '0;
        rsp_err_nx   = 1'b0;
        rsd_nx       = rsp_rsd;
        rxd_nx       = rsp_rxd;
        rkd_nx       = rsp_rkd;
        re_nx        = 1'b0;
        we_nx        = 1'b0;
        rd_nx        = bank_rd;
        rs_nx        = bank_rs;
        rx_nx        = bank_rx;
        rk_nx        = bank_rk;
        wb_nx        = bank_wb;

        case (state)
            IDLE: begin
                if (found) begin
                    state_nx    = ACCESS;
                    ptr_nx      = win;
                    owner_nx    = win;
                    gnt_nx[win] = 1'b1;
                    is_wr_nx    = req_we[win];
                    err_nx      = req_we[win] && pc_hit;
                    re_nx       = !req_we[win];
                    we_nx       = req_we[win] && !pc_hit;
                    rd_nx       = rd_a[win];
                    rs_nx       = rs_a[win];
                    rx_nx       = rx_a[win];
                    rk_nx       = rk_a[win];
                    wb_nx       = wb_a[win];
                end
            end
            ACCESS: begin
                if (is_wr) begin
                    state_nx            = RESP;
                    rsp_valid_nx[owner] = 1'b1;
                    rsp_err_nx          = err;
                end else begin
                    state_nx = RDWAIT;
                end
            end
            RDWAIT: begin
                state_nx            = RESP;
                rsp_valid_nx[owner] = 1'b1;
                rsd_nx              = bank_rsd;
                rxd_nx              = bank_rxd;
                rkd_nx              = bank_rkd;
            end
            RESP: begin
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase

        busy_nx = (state_nx != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            ptr       <= PW'(NREQ - 1);
            owner     <= '0;
            is_wr     <= 1'b0;
            err       <= 1'b0;
            gnt       <= '0;
            rsp_valid <= '0;
            rsp_err   <= 1'b0;
            rsp_rsd   <= '0;
            rsp_rxd   <= '0;
            rsp_rkd   <= '0;
            busy      <= 1'b0;
            bank_re   <= 1'b0;
            bank_we   <= 1'b0;
            bank_rd   <= '0;
            bank_rs   <= '0;
            bank_rx   <= '0;
            bank_rk   <= '0;
            bank_wb   <= '0;
        end else begin
            state     <= state_nx;
            ptr       <= ptr_nx;
            owner     <= owner_nx;
            is_wr     <= is_wr_nx;
            err       <= err_nx;
            gnt       <= gnt_nx;
            rsp_valid <= rsp_valid_nx;
            rsp_err   <= rsp_err_nx;
            rsp_rsd   <= rsd_nx;
            rsp_rxd   <= rxd_nx;
            rsp_rkd   <= rkd_nx;
            busy      <= busy_nx;
            bank_re   <= re_nx;
            bank_we   <= we_nx;
            bank_rd   <= rd_nx;
            bank_rs   <= rs_nx;
            bank_rx   <= rx_nx;
            bank_rk   <= rk_nx;
            bank_wb   <= wb_nx;
        end
    end

endmodule
